// File: rtl/floor_pkg.sv
`default_nettype none
//==============================================================================
// Module   : floor_pkg
// Brief    : Shared types, LFSR taps and x-position mapping for the scroller
// Revision : 1.0
//==============================================================================
package floor_pkg;

   typedef logic [9:0] coord_t;

   typedef enum logic [1:0] {
      INIT   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2
   } scroll_state_t;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Rotate left by rot, keep the low 10 bits, fold once into [0, x_range).
   function automatic coord_t x_map(input logic [15:0] lfsr, input int rot, input coord_t x_range);
      coord_t w_r;
      w_r = '0;
      for (int b = 0; b < 10; b++) begin
         w_r[4'(b)] = lfsr[4'((b + 16 - (rot % 16)) % 16)];
      end
      return (w_r >= x_range) ? (w_r - x_range) : w_r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/floor_lfsr.sv
`default_nettype none
//==============================================================================
// Module   : floor_lfsr
// Brief    : Free-running 16-bit Galois LFSR used to randomise respawn x
// Revision : 1.0
//==============================================================================
module floor_lfsr
   import floor_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        Clk,
   input  logic        Reset_n,
   output logic [15:0] lfsr
);

   logic [15:0] r_lfsr;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_lfsr <= SEED;
      end else begin
         r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
      end
   end

   assign lfsr = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/floor_scroller.sv
`default_nettype none
//==============================================================================
// Module   : floor_scroller
// Brief    : N-floor vertical scroller with respawn, speed-up, pause, restart
// Revision : 1.0
//==============================================================================
module floor_scroller
   import floor_pkg::*;
#(
   parameter int          N_FLOORS       = 5,
   parameter int          Y_MIN          = 0,
   parameter int          Y_MAX          = 479,
   parameter int          X_MAX          = 639,
   parameter int          X_SIZE         = 90,
   parameter int          Y_SIZE         = 20,
   parameter int          Y_START        = 120,
   parameter int          Y_PITCH        = 80,
   parameter int          STEP_INIT      = 1,
   parameter int          STEP_MAX       = 4,
   parameter int          SPEEDUP_FRAMES = 600,
   parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
   input  logic                       Clk,
   input  logic                       Reset_n,
   input  logic                       frame_clk,
   input  logic                       pause,
   input  logic                       restart,
   output coord_t [N_FLOORS-1:0]      floor_x,
   output coord_t [N_FLOORS-1:0]      floor_y,
   output logic                       floors_valid,
   output logic [2:0]                 scroll_step,
   output logic [N_FLOORS-1:0]        respawn_mask
);

   localparam coord_t                c_X_RANGE   = coord_t'(X_MAX + 1 - X_SIZE);
   localparam coord_t                c_Y_RESPAWN = coord_t'(Y_MAX - Y_SIZE);
   localparam logic [10:0]           c_Y_MIN     = 11'(Y_MIN);
   localparam int                    c_CNT_W     = $clog2(SPEEDUP_FRAMES + 1);
   localparam logic [c_CNT_W-1:0]    c_CNT_LAST  = c_CNT_W'(SPEEDUP_FRAMES - 1);
   localparam logic [2:0]            c_STEP_INIT = 3'(STEP_INIT);
   localparam logic [2:0]            c_STEP_MAX  = 3'(STEP_MAX);
   localparam logic [3:0]            c_IDX_LAST  = 4'(N_FLOORS - 1);

   generate
      if (N_FLOORS < 1 || N_FLOORS > 16) begin : g_bad_count
         $error("floor_scroller: N_FLOORS must be 1..16");
      end
      if (Y_START + (N_FLOORS - 1) * Y_PITCH > Y_MAX - Y_SIZE) begin : g_bad_pitch
         $error("floor_scroller: initial floors do not fit on screen");
      end
      if (X_MAX + 1 - X_SIZE < 512) begin : g_bad_xrange
         $error("floor_scroller: single-fold x map needs X_RANGE >= 512");
      end
   endgenerate

   scroll_state_t            r_state, w_state_nxt;
   logic [3:0]               r_init_idx, w_idx_nxt;
   coord_t [N_FLOORS-1:0]    r_x, w_x_nxt;
   coord_t [N_FLOORS-1:0]    r_y, w_y_nxt;
   logic                     r_valid, w_valid_nxt;
   logic [2:0]               r_step, w_step_nxt;
   logic [c_CNT_W-1:0]       r_cnt, w_cnt_nxt;
   logic [N_FLOORS-1:0]      r_mask, w_mask_nxt;
   logic                     r_frame_q;
   logic                     w_fe;
   logic [15:0]              w_lfsr;

   floor_lfsr #(
      .SEED    (LFSR_SEED)
   ) u_lfsr (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .lfsr    (w_lfsr)
   );

   assign w_fe = frame_clk & ~r_frame_q;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= INIT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_init_idx;
      w_x_nxt     = r_x;
      w_y_nxt     = r_y;
      w_valid_nxt = r_valid;
      w_step_nxt  = r_step;
      w_cnt_nxt   = r_cnt;
      w_mask_nxt  = '0;

      if (restart) begin
         w_state_nxt = INIT;
         w_idx_nxt   = '0;
         w_valid_nxt = 1'b0;
         w_step_nxt  = c_STEP_INIT;
         w_cnt_nxt   = '0;
      end else begin
         unique case (r_state)
            INIT: begin
               for (int i = 0; i < N_FLOORS; i++) begin
                  if (r_init_idx == 4'(i)) begin
                     w_y_nxt[i] = coord_t'(Y_START + i * Y_PITCH);
                     w_x_nxt[i] = x_map(w_lfsr, 3 * i, c_X_RANGE);
                  end
               end
               if (r_init_idx == c_IDX_LAST) begin
                  w_state_nxt = RUN;
                  w_valid_nxt = 1'b1;
               end else begin
                  w_idx_nxt = r_init_idx + 4'd1;
               end
            end
            RUN: begin
               if (pause) begin
                  w_state_nxt = PAUSED;
               end else if (w_fe) begin
                  // 11-bit compare so Y_MIN + step cannot wrap below zero.
                  for (int i = 0; i < N_FLOORS; i++) begin
                     if ({1'b0, r_y[i]} < (c_Y_MIN + {8'd0, r_step})) begin
                        w_y_nxt[i]    = c_Y_RESPAWN;
                        w_x_nxt[i]    = x_map(w_lfsr, 3 * i, c_X_RANGE);
                        w_mask_nxt[i] = 1'b1;
                     end else begin
                        w_y_nxt[i] = r_y[i] - {7'd0, r_step};
                     end
                  end
                  if (r_cnt == c_CNT_LAST) begin
                     w_cnt_nxt = '0;
                     if (r_step < c_STEP_MAX) begin
                        w_step_nxt = r_step + 3'd1;
                     end
                  end else begin
                     w_cnt_nxt = r_cnt + 1'b1;
                  end
               end
            end
            PAUSED: begin
               if (!pause) begin
                  w_state_nxt = RUN;
               end
            end
            default: begin
               w_state_nxt = INIT;
               w_idx_nxt   = '0;
               w_valid_nxt = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_frame_q  <= 1'b0;
         r_init_idx <= '0;
         r_x        <= '0;
         r_y        <= '0;
         r_valid    <= 1'b0;
         r_step     <= c_STEP_INIT;
         r_cnt      <= '0;
         r_mask     <= '0;
      end else begin
         r_frame_q  <= frame_clk;
         r_init_idx <= w_idx_nxt;
         r_x        <= w_x_nxt;
         r_y        <= w_y_nxt;
         r_valid    <= w_valid_nxt;
         r_step     <= w_step_nxt;
         r_cnt      <= w_cnt_nxt;
         r_mask     <= w_mask_nxt;
      end
   end

   assign floor_x      = r_x;
   assign floor_y      = r_y;
   assign floors_valid = r_valid;
   assign scroll_step  = r_step;
   assign respawn_mask = r_mask;

endmodule
`default_nettype wire

// File: tb/tb_floor_scroller.sv
`default_nettype none
//==============================================================================
// Module   : tb_floor_scroller
// Brief    : Self-checking bench with a behavioural floor model and directed pins
// Revision : 1.0
//==============================================================================
module tb_floor_scroller;
   import floor_pkg::*;

   localparam int NF      = 5;
   localparam int SPEEDUP = 4;
   localparam int YSTART  = 120;
   localparam int YPITCH  = 80;
   localparam int YRESP   = 479 - 20;
   localparam int XRANGE  = 639 + 1 - 90;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 frame_clk = 1'b0;
   logic                 pause = 1'b0;
   logic                 restart = 1'b0;
   coord_t [NF-1:0]      floor_x;
   coord_t [NF-1:0]      floor_y;
   logic                 floors_valid;
   logic [2:0]           scroll_step;
   logic [NF-1:0]        respawn_mask;

   int total = 0;
   int bad   = 0;
   int exp_init[NF] = '{120, 200, 280, 360, 440};

   floor_scroller #(
      .N_FLOORS       (NF),
      .SPEEDUP_FRAMES (SPEEDUP)
   ) dut (
      .Clk          (clk),
      .Reset_n      (rst_n),
      .frame_clk    (frame_clk),
      .pause        (pause),
      .restart      (restart),
      .floor_x      (floor_x),
      .floor_y      (floor_y),
      .floors_valid (floors_valid),
      .scroll_step  (scroll_step),
      .respawn_mask (respawn_mask)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_y[NF], m_x[NF];
   int m_step, m_cnt, m_idx, m_lf;
   bit m_valid, m_paused, m_fq, m_fe;
   bit [NF-1:0] m_mask;

   function automatic int lf_next(input int l);
      return (l >> 1) ^ (((l & 1) != 0) ? 'hB400 : 0);
   endfunction

   function automatic int xpos(input int l, input int fl);
      int s, rot, r;
      s   = (3 * fl) % 16;
      rot = ((l << s) | (l >> (16 - s))) & 'hFFFF;
      r   = rot % 1024;
      return (r >= XRANGE) ? r - XRANGE : r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NF; i++) begin m_y[i] = 0; m_x[i] = 0; end
         m_step = 1; m_cnt = 0; m_idx = 0; m_lf = 'hACE1;
         m_valid = 0; m_paused = 0; m_fq = 0; m_mask = '0;
      end else begin
         m_fe   = frame_clk && !m_fq;
         m_fq   = frame_clk;
         m_mask = '0;
         if (restart) begin
            m_idx = 0; m_valid = 0; m_step = 1; m_cnt = 0; m_paused = 0;
         end else if (m_idx < NF) begin
            m_y[m_idx] = YSTART + m_idx * YPITCH;
            m_x[m_idx] = xpos(m_lf, m_idx);
            m_idx++;
            if (m_idx == NF) m_valid = 1;
         end else if (m_paused) begin
            if (!pause) m_paused = 0;
         end else if (pause) begin
            m_paused = 1;
         end else if (m_fe) begin
            for (int i = 0; i < NF; i++) begin
               if (m_y[i] < 0 + m_step) begin
                  m_y[i] = YRESP;
                  m_x[i] = xpos(m_lf, i);
                  m_mask[i] = 1'b1;
               end else begin
                  m_y[i] = m_y[i] - m_step;
               end
            end
            m_cnt++;
            if (m_cnt == SPEEDUP) begin
               m_cnt = 0;
               if (m_step < 4) m_step++;
            end
         end
         m_lf = lf_next(m_lf);
      end
   end

   // Compare every cycle at the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_valid", int'(floors_valid), 0);
         chk("rst_step", int'(scroll_step), 1);
         chk("rst_mask", int'(respawn_mask), 0);
         chk("rst_y0", int'(floor_y[0]), 0);
         chk("rst_x0", int'(floor_x[0]), 0);
      end else begin
         chk("valid", int'(floors_valid), int'(m_valid));
         chk("step", int'(scroll_step), m_step);
         chk("mask", int'(respawn_mask), int'(m_mask));
         if (m_valid) begin
            for (int i = 0; i < NF; i++) begin
               chk($sformatf("y%0d", i), int'(floor_y[i]), m_y[i]);
               chk($sformatf("x%0d", i), int'(floor_x[i]), m_x[i]);
            end
         end
      end
   end

   task automatic fe_pulse();
      @(negedge clk); frame_clk = 1'b1;
      @(negedge clk); frame_clk = 1'b0;
   endtask

   task automatic chk_init_set(input string tag);
      for (int i = 0; i < NF; i++) chk($sformatf("%s_y%0d", tag, i), int'(floor_y[i]), exp_init[i]);
      chk({tag, "_step"}, int'(scroll_step), 1);
      chk({tag, "_valid"}, int'(floors_valid), 1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("hold_rst_valid", int'(floors_valid), 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("init_not_done", int'(floors_valid), 0);
      @(negedge clk);
      chk_init_set("init");
      chk("init_x0_pin", int'(floor_x[0]), 225);
      chk("init_x1_pin", int'(floor_x[1]), 353);
      for (int i = 0; i < NF; i++) chk($sformatf("init_xrange%0d", i), int'(floor_x[i] < 10'(XRANGE)), 1);

      repeat (3) fe_pulse();
      for (int i = 0; i < NF; i++) chk($sformatf("run3_y%0d", i), int'(floor_y[i]), exp_init[i] - 3);
      chk("run3_step", int'(scroll_step), 1);
      chk("run3_mask", int'(respawn_mask), 0);

      fe_pulse();
      chk("fe4_step", int'(scroll_step), 2);
      chk("fe4_y0", int'(floor_y[0]), 116);
      repeat (12) fe_pulse();
      chk("fe16_step", int'(scroll_step), 4);
      chk("fe16_y0", int'(floor_y[0]), 80);
      repeat (20) fe_pulse();
      chk("fe36_step", int'(scroll_step), 4);
      chk("fe36_y0", int'(floor_y[0]), 0);
      chk("fe36_y1", int'(floor_y[1]), 80);
      fe_pulse();
      chk("resp_y0", int'(floor_y[0]), 459);
      chk("resp_mask", int'(respawn_mask), 1);
      chk("resp_y1", int'(floor_y[1]), 76);
      chk("resp_x0_range", int'(floor_x[0] < 10'(XRANGE)), 1);
      @(negedge clk);
      chk("resp_mask_clear", int'(respawn_mask), 0);

      pause = 1'b1;
      repeat (10) fe_pulse();
      chk("pause_y0", int'(floor_y[0]), 459);
      chk("pause_y1", int'(floor_y[1]), 76);
      chk("pause_step", int'(scroll_step), 4);
      @(negedge clk); pause = 1'b0;
      repeat (2) @(negedge clk);
      fe_pulse();
      chk("resume_y0", int'(floor_y[0]), 455);
      chk("resume_y1", int'(floor_y[1]), 72);

      @(negedge clk); restart = 1'b1;
      @(negedge clk); restart = 1'b0; frame_clk = 1'b1;
      chk("restart_valid", int'(floors_valid), 0);
      chk("restart_step", int'(scroll_step), 1);
      @(negedge clk); frame_clk = 1'b0;
      repeat (4) @(negedge clk);
      chk_init_set("restart");
      repeat (3) fe_pulse();
      chk("restart_cnt3", int'(scroll_step), 1);
      fe_pulse();
      chk("restart_cnt4", int'(scroll_step), 2);

      @(negedge clk); restart = 1'b1;
      @(negedge clk); restart = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midinit_rst_y0", int'(floor_y[0]), 0);
      chk("midinit_rst_valid", int'(floors_valid), 0);
      @(negedge clk); rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk_init_set("reinit");
      chk("reinit_x0_pin", int'(floor_x[0]), 225);

      repeat (3000) begin
         @(negedge clk);
         frame_clk = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 60) == 0) pause = ~pause;
         restart = ($urandom_range(0, 700) == 0);
      end
      @(negedge clk);
      frame_clk = 1'b0; pause = 1'b0; restart = 1'b0;
      repeat (4) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
